// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store unit with an internal word-organised data RAM.
// Requests are validated in IDLE, optionally delayed in WAIT, then answered with a one-cycle RESP pulse.
module lsu_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        LoadM,
    input  logic        StoreM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALU_ResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        DoneM,
    output logic        ErrM
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    function automatic logic isLegal(input logic ld, input logic st, input logic [2:0] f3,
                                     input logic [31:0] addr);
        return !((ld && st) || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                 (st && f3[2]) || ((f3[1:0] == 2'b01) && addr[0]) ||
                 ((f3 == 3'b010) && (addr[1:0] != 2'b00)) || (addr[31:2] >= DEPTH_LIM));
    endfunction

    function automatic logic [3:0] byteEn(input logic [2:0] f3, input logic [1:0] lane);
        case (f3[1:0])
            2'b00:   return 4'b0001 << lane;
            2'b01:   return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data across every lane it could land in.
    function automatic logic [31:0] laneData(input logic [2:0] f3, input logic [31:0] d);
        case (f3[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] word,
                                           input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'd0, b};
            3'b101:  return {16'd0, h};
            default: return word;
        endcase
    endfunction

    state_t      state_r, nextState_s;
    logic [3:0]  waitCnt_r, nextWaitCnt_s;
    logic        isStore_r;
    logic [2:0]  funct3_r;
    logic [AW+1:0] addrLo_r;
    logic [31:0] wdata_r;
    logic [31:0] readData_r;
    logic        done_r, err_r;
    logic        latch_s, reqErr_s, doAccess_s, accStore_s, memWe_s;
    logic [2:0]  accF3_s;
    logic [AW+1:0] accAddr_s;
    logic [31:0] accData_s, accWord_s, wrLanes_s;
    logic [3:0]  accBe_s;
    logic [31:0] mem [DEPTH_WORDS];

    // Next-state, stall and access-select logic.
    always_comb begin
        nextState_s   = state_r;
        nextWaitCnt_s = waitCnt_r;
        StallM        = 1'b0;
        latch_s       = 1'b0;
        reqErr_s      = 1'b0;
        doAccess_s    = 1'b0;
        accStore_s    = isStore_r;
        accF3_s       = funct3_r;
        accAddr_s     = addrLo_r;
        accData_s     = wdata_r;
        case (state_r)
            IDLE: begin
                if (LoadM || StoreM) begin
                    StallM  = 1'b1;
                    latch_s = 1'b1;
                    if (!isLegal(LoadM, StoreM, funct3M, ALU_ResultM)) begin
                        reqErr_s    = 1'b1;
                        nextState_s = RESP;
                    end else if (WAIT_CYCLES == 0) begin
                        // Zero-latency build: commit straight from the request inputs.
                        doAccess_s  = 1'b1;
                        accStore_s  = StoreM;
                        accF3_s     = funct3M;
                        accAddr_s   = ALU_ResultM[AW+1:0];
                        accData_s   = WriteDataM;
                        nextState_s = RESP;
                    end else begin
                        nextWaitCnt_s = WAIT_INIT;
                        nextState_s   = WAIT;
                    end
                end else begin
                    nextState_s = IDLE;
                end
            end
            WAIT: begin
                StallM = 1'b1;
                if (waitCnt_r != 4'd0) begin
                    nextWaitCnt_s = waitCnt_r - 4'd1;
                end else begin
                    doAccess_s  = 1'b1;
                    nextState_s = RESP;
                end
            end
            RESP:    nextState_s = IDLE;
            default: nextState_s = IDLE;
        endcase
    end

    assign accWord_s = mem[accAddr_s[AW+1:2]];
    assign accBe_s   = byteEn(accF3_s, accAddr_s[1:0]);
    assign wrLanes_s = laneData(accF3_s, accData_s);
    // A reset on the commit edge must also cancel the pending write.
    assign memWe_s   = doAccess_s && accStore_s && rst;

    // Byte-lane RAM write port; contents survive reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (memWe_s && accBe_s[i]) begin
                mem[accAddr_s[AW+1:2]][8*i +: 8] <= wrLanes_s[8*i +: 8];
            end
        end
    end

    // Control state, request capture and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= IDLE;
            waitCnt_r  <= 4'd0;
            isStore_r  <= 1'b0;
            funct3_r   <= 3'd0;
            addrLo_r   <= '0;
            wdata_r    <= 32'd0;
            readData_r <= 32'd0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r   <= nextState_s;
            waitCnt_r <= nextWaitCnt_s;
            done_r    <= (nextState_s == RESP);
            err_r     <= reqErr_s;
            if (latch_s) begin
                isStore_r <= StoreM;
                funct3_r  <= funct3M;
                addrLo_r  <= ALU_ResultM[AW+1:0];
                wdata_r   <= WriteDataM;
            end
            if (doAccess_s && !accStore_s) begin
                readData_r <= extend(accF3_s, accWord_s, accAddr_s[1:0]);
            end
        end
    end

    assign ReadDataM = readData_r;
    assign DoneM     = done_r;
    assign ErrM      = err_r;

endmodule
